// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: MULT/MULTU/DIV/DIVU run for a fixed number of cycles, MTHI/MTLO write at once.
// Latency MULT_CYCLES or DIV_CYCLES; Start is ignored while Busy and on the completion edge.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [63:0]   res_q, res_d;

    logic          is_div, is_signed, a_neg, b_neg;
    logic [31:0]   mag_a, mag_b, quo, rem;
    logic [63:0]   prod_mag;

    // Sign-magnitude datapath: the most-negative / -1 divide falls out as 0x80000000 rem 0.
    // The result is registered, so each cycle count must be at least 2.
    always_comb begin
        is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_neg     = is_signed & a_q[31];
        b_neg     = is_signed & b_q[31];
        mag_a     = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b     = b_neg ? (~b_q + 32'd1) : b_q;
        quo       = '0;
        rem       = '0;
        if (mag_b != '0) begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        prod_mag = {32'd0, mag_a} * {32'd0, mag_b};
        if (is_div) begin
            res_d = {(a_neg ? (~rem + 32'd1) : rem),
                     ((a_neg ^ b_neg) ? (~quo + 32'd1) : quo)};
        end else begin
            res_d = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            op_d    = Op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = Op;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    // Divide by zero leaves HI/LO untouched.
                    if (!(is_div && (b_q == '0))) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset, Start;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int cycles_of(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Architectural effect of an accepted operation on HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge with the unit idle; returns at the first negedge with Busy low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude);
        int          n;
        int          exp_n;
        logic [31:0] h0, l0;
        exp_n = cycles_of(op);
        h0 = m_hi;
        l0 = m_lo;
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
        n = 0;
        while (Busy === 1'b1 && n < 50) begin
            check("hold_hi", HI, h0);
            check("hold_lo", LO, l0);
            n++;
            if (intrude && n == 2) begin
                Start = 1'b1; Op = 3'd6; A = 32'h55;
            end else if (intrude && n == exp_n) begin
                Start = 1'b1; Op = 3'($urandom); A = $urandom; B = $urandom;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        check("busy_cycles", 32'(n), 32'(exp_n));
        model(op, a, b);
        check("busy_low", {31'd0, Busy}, 32'd0);
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        Start = 1'b1; Op = 3'd5; A = 32'hDEAD;
        @(negedge clk);
        Start = 1'b0;
        reset = 1'b0;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd5, 32'h11, 32'd0, 1'b0);
        run_op(3'd6, 32'h22, 32'd0, 1'b0);
        run_op(3'd4, 32'd7, 32'd0, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_no_x", ^{HI, LO, Busy} === 1'bx ? 32'd1 : 32'd0, 32'd0);
        run_op(3'd0, 32'h1234, 32'd5, 1'b0);
        run_op(3'd7, 32'h5678, 32'd5, 1'b0);

        // MTLO during RUN and Start on the completion edge are both ignored; then back-to-back issue.
        run_op(3'd1, 32'h0001_0003, 32'hFFFF_0007, 1'b1);
        run_op(3'd1, 32'd12345, 32'd678, 1'b0);

        // Reset in the fourth RUN cycle of a divide.
        Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);
        check("abort_late_busy", {31'd0, Busy}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(7, 0));
            ra  = $urandom;
            rb  = ($urandom_range(3, 0) == 0) ? 32'd0 :
                  ($urandom_range(1, 0) == 0) ? 32'($urandom_range(20, 1)) : $urandom;
            if ($urandom_range(7, 0) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, ($urandom_range(1, 0) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning the number of cycles Busy stays high for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning the number of cycles Busy stays high for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Start, input, 1 bit: one-cycle strobe that qualifies Op in the EX stage.
REQ-006 The block SHALL have port Op, input, 3 bits: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-007 The block SHALL have port A, input, 32 bits: rs operand.
REQ-008 The block SHALL have port B, input, 32 bits: rt operand.
REQ-009 The block SHALL have port Busy, output, 1 bit: an operation is in progress; it is consumed by the hazard unit's (Busy||Start)&&MultDiv stall term.
REQ-010 The block SHALL have port HI, output, 32 bits: registered HI value, read by mfhi.
REQ-011 The block SHALL have port LO, output, 32 bits: registered LO value, read by mflo.

Function
REQ-012 States SHALL be IDLE and RUN, with a down-counter cnt wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, a sampled Start with Op in {MULT, MULTU, DIV, DIVU} SHALL latch A, B and Op, load cnt with the matching cycle count, and enter RUN.
REQ-014 Busy SHALL be registered: 1 in every cycle while in RUN, 0 in IDLE, and never combinationally dependent on Start.
REQ-015 Start at edge k SHALL make Busy high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 At edge k+N, HI and LO SHALL update and Busy SHALL fall together, so the new values are visible in the first cycle Busy=0.
REQ-017 HI and LO SHALL hold their previous values throughout RUN.
REQ-018 MULT SHALL produce {HI,LO} = signed 64-bit product of the latched A and B.
REQ-019 MULTU SHALL produce {HI,LO} = unsigned 64-bit product of the latched A and B.
REQ-020 DIV SHALL set LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-021 DIVU SHALL set LO = unsigned quotient and HI = unsigned remainder.
REQ-022 For DIV/DIVU with B = 0, the block SHALL still run the full DIV_CYCLES and SHALL leave HI and LO unchanged at completion.
REQ-023 For DIV with A = 0x80000000 and B = 0xFFFFFFFF, the block SHALL set LO = 0x80000000 and HI = 0.
REQ-024 MTHI in IDLE with Start SHALL write HI = A at that edge, leave LO unchanged, and keep Busy = 0.
REQ-025 MTLO in IDLE with Start SHALL write LO = A at that edge, leave HI unchanged, and keep Busy = 0.
REQ-026 Start during RUN, for any Op, SHALL be ignored: no relatch, no HI/LO write, no counter change.
REQ-027 Start with Op none or reserved SHALL have no effect.
REQ-028 Start in the same cycle as the completion edge (cnt expiring) SHALL be ignored; back-to-back issue is possible only from the following cycle.
REQ-029 The arithmetic SHALL be implemented as a multi-cycle or registered datapath; a single-cycle 64-bit combinational divider feeding HI/LO directly is not permitted.
REQ-030 Operands SHALL be taken only from the latched copies, so A and B may change freely after the Start cycle.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set HI=0, LO=0, Busy=0, cnt=0 and state=IDLE.
REQ-032 Reset SHALL take priority over Start.
REQ-033 Reset during RUN SHALL abort the operation with no HI/LO update.
REQ-034 Outputs SHALL be defined from the first cycle after reset deasserts.

Verification
REQ-035 MULT with A=0xFFFFFFFE (-2) and B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 MULTU with A=0xFFFFFFFF and B=0xFFFFFFFF -> after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 DIV with A=0xFFFFFFF9 (-7) and B=2 -> Busy high exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with A=7 and B=0 after MTHI 0x11 / MTLO 0x22 -> HI=0x11, LO=0x22 unchanged after 10 cycles.
REQ-038 MULT started, then Start+MTLO (A=0x55) at cycle 2 of RUN -> MTLO ignored, final LO is the product; a new MULT issued on the cycle after Busy falls -> accepted.
REQ-039 DIV started, reset asserted at RUN cycle 4 -> next cycle Busy=0, HI=0, LO=0, and no later update occurs.
REQ-040 DIV with A=0x80000000 and B=0xFFFFFFFF -> LO=0x80000000, HI=0, and no X on any output.
